// File: rtl/l2_req_buffer.sv
// l2_req_buffer: queues L2 requests, limits requests in flight and
// returns the L2 response to the arbiter one cycle later.
module l2_req_buffer #(
  parameter int abits                  = 1,
  parameter int outstd_max             = 1,
  parameter int L2_REQ_TYPE_BITS       = 4,
  parameter int CFG_CPU_ADDR_BITS      = 48,
  parameter int L1CACHE_LINE_BITS      = 256,
  parameter int L1CACHE_BYTES_PER_LINE = 32
) (
  input  logic                              i_clk,
  input  logic                              i_nrst,
  input  logic                              i_req_valid,
  output logic                              o_req_ready,
  input  logic [L2_REQ_TYPE_BITS-1:0]       i_req_type,
  input  logic [CFG_CPU_ADDR_BITS-1:0]      i_req_addr,
  input  logic [2:0]                        i_req_size,
  input  logic [2:0]                        i_req_prot,
  input  logic [L1CACHE_LINE_BITS-1:0]      i_req_wdata,
  input  logic [L1CACHE_BYTES_PER_LINE-1:0] i_req_wstrb,
  output logic                              o_resp_valid,
  output logic [L1CACHE_LINE_BITS-1:0]      o_resp_rdata,
  output logic [1:0]                        o_resp_status,
  output logic                              o_req_valid,
  input  logic                              i_req_ready,
  output logic [L2_REQ_TYPE_BITS-1:0]       o_req_type,
  output logic [CFG_CPU_ADDR_BITS-1:0]      o_req_addr,
  output logic [2:0]                        o_req_size,
  output logic [2:0]                        o_req_prot,
  output logic [L1CACHE_LINE_BITS-1:0]      o_req_wdata,
  output logic [L1CACHE_BYTES_PER_LINE-1:0] o_req_wstrb,
  input  logic                              i_resp_valid,
  input  logic [L1CACHE_LINE_BITS-1:0]      i_resp_rdata,
  input  logic [1:0]                        i_resp_status
);

  localparam int DEPTH = 2 ** abits;
  localparam logic [abits:0] DEPTH_W = (abits + 1)'(DEPTH);
  localparam logic [2:0] OMAX = 3'(outstd_max);

  typedef struct packed {
    logic [L2_REQ_TYPE_BITS-1:0]       rtype;
    logic [CFG_CPU_ADDR_BITS-1:0]      addr;
    logic [2:0]                        size;
    logic [2:0]                        prot;
    logic [L1CACHE_LINE_BITS-1:0]      wdata;
    logic [L1CACHE_BYTES_PER_LINE-1:0] wstrb;
  } entry_t;

  entry_t                         mem_q [DEPTH];
  entry_t                         wr_ent;
  entry_t                         head;
  logic [abits-1:0]               wr_ptr_q, wr_ptr_d;
  logic [abits-1:0]               rd_ptr_q, rd_ptr_d;
  logic [abits:0]                 count_q, count_d;
  logic [2:0]                     outstd_q, outstd_d;
  logic                           en_q;
  logic                           resp_valid_q;
  logic [L1CACHE_LINE_BITS-1:0]   resp_rdata_q, resp_rdata_d;
  logic [1:0]                     resp_status_q, resp_status_d;
  logic                           push, pop;

  // en_q keeps ready low while in reset and for the release cycle
  assign o_req_ready = en_q & (count_q != DEPTH_W);
  assign o_req_valid = (count_q != '0) & (outstd_q < OMAX);
  assign push = i_req_valid & o_req_ready;
  assign pop  = o_req_valid & i_req_ready;

  assign wr_ent = '{rtype: i_req_type, addr: i_req_addr,
                    size: i_req_size, prot: i_req_prot,
                    wdata: i_req_wdata, wstrb: i_req_wstrb};
  assign head = mem_q[rd_ptr_q];

  assign o_req_type  = head.rtype;
  assign o_req_addr  = head.addr;
  assign o_req_size  = head.size;
  assign o_req_prot  = head.prot;
  assign o_req_wdata = head.wdata;
  assign o_req_wstrb = head.wstrb;

  assign o_resp_valid  = resp_valid_q;
  assign o_resp_rdata  = resp_rdata_q;
  assign o_resp_status = resp_status_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstd_d      = outstd_q;
    resp_rdata_d  = resp_rdata_q;
    resp_status_d = resp_status_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // a response with nothing in flight saturates at zero
    if (pop & ~i_resp_valid)
      outstd_d = outstd_q + 1'b1;
    else if (~pop & i_resp_valid & (outstd_q != '0))
      outstd_d = outstd_q - 1'b1;
    if (i_resp_valid) begin
      resp_rdata_d  = i_resp_rdata;
      resp_status_d = i_resp_status;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstd_q      <= '0;
      en_q          <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_status_q <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= wr_ent;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstd_q      <= outstd_d;
      en_q          <= 1'b1;
      resp_valid_q  <= i_resp_valid;
      resp_rdata_q  <= resp_rdata_d;
      resp_status_q <= resp_status_d;
    end
  end

endmodule

// File: tb/tb_l2_req_buffer.sv
// tb_l2_req_buffer: vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_l2_req_buffer;

  localparam int DEPTH = 2;
  localparam int OMAX  = 1;
  localparam logic [3:0] CACHED = 4'b0010;

  logic         i_clk = 1'b0;
  logic         i_nrst;
  logic         i_req_valid;
  logic         o_req_ready;
  logic [3:0]   i_req_type;
  logic [47:0]  i_req_addr;
  logic [2:0]   i_req_size;
  logic [2:0]   i_req_prot;
  logic [255:0] i_req_wdata;
  logic [31:0]  i_req_wstrb;
  logic         o_resp_valid;
  logic [255:0] o_resp_rdata;
  logic [1:0]   o_resp_status;
  logic         o_req_valid;
  logic         i_req_ready;
  logic [3:0]   o_req_type;
  logic [47:0]  o_req_addr;
  logic [2:0]   o_req_size;
  logic [2:0]   o_req_prot;
  logic [255:0] o_req_wdata;
  logic [31:0]  o_req_wstrb;
  logic         i_resp_valid;
  logic [255:0] i_resp_rdata;
  logic [1:0]   i_resp_status;

  always #5 i_clk = ~i_clk;

  l2_req_buffer #(.abits(1), .outstd_max(OMAX)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_type(i_req_type), .i_req_addr(i_req_addr),
    .i_req_size(i_req_size), .i_req_prot(i_req_prot),
    .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata),
    .o_resp_status(o_resp_status),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
    .o_req_type(o_req_type), .o_req_addr(o_req_addr),
    .o_req_size(o_req_size), .o_req_prot(o_req_prot),
    .o_req_wdata(o_req_wdata), .o_req_wstrb(o_req_wstrb),
    .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata),
    .i_resp_status(i_resp_status)
  );

  typedef struct {
    logic [3:0]   t;
    logic [47:0]  a;
    logic [2:0]   s;
    logic [2:0]   p;
    logic [255:0] d;
    logic [31:0]  b;
  } req_t;

  typedef struct {
    logic        pv;
    logic [47:0] addr;
    logic        lr;
    logic        rv;
    logic [7:0]  rb;
    logic [1:0]  rs;
    logic        e_rdy;
    logic        e_vld;
    logic [47:0] e_addr;
    logic        e_rv;
    logic [7:0]  e_rb;
    logic [1:0]  e_rs;
  } vec_t;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic req_t mk_req(input logic [47:0] a);
    req_t r;
    r.t = CACHED;
    r.a = a;
    r.s = 3'd5;
    r.p = 3'd0;
    r.d = '0;
    r.b = '1;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.t = 4'($urandom);
    r.a = {16'($urandom), 32'($urandom)};
    r.s = 3'($urandom);
    r.p = 3'($urandom);
    for (int k = 0; k < 8; k++) r.d[k*32 +: 32] = $urandom;
    r.b = $urandom;
    return r;
  endfunction

  task automatic drive(input logic v, input req_t r);
    i_req_valid = v;
    i_req_type  = r.t;
    i_req_addr  = r.a;
    i_req_size  = r.s;
    i_req_prot  = r.p;
    i_req_wdata = r.d;
    i_req_wstrb = r.b;
  endtask

  task automatic idle();
    drive(1'b0, mk_req('0));
    i_req_ready   = 1'b0;
    i_resp_valid  = 1'b0;
    i_resp_rdata  = '0;
    i_resp_status = '0;
  endtask

  task automatic reset_dut();
    @(negedge i_clk);
    idle();
    i_nrst = 1'b0;
    repeat (3) @(negedge i_clk);
    i_nrst = 1'b1;
    @(negedge i_clk);
  endtask

  function automatic vec_t mkv(
    input logic pv, input logic [47:0] addr, input logic lr,
    input logic rv, input logic [7:0] rb, input logic [1:0] rs,
    input logic e_rdy, input logic e_vld, input logic [47:0] e_addr,
    input logic e_rv, input logic [7:0] e_rb, input logic [1:0] e_rs);
    vec_t v;
    v.pv = pv; v.addr = addr; v.lr = lr;
    v.rv = rv; v.rb = rb; v.rs = rs;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_addr = e_addr;
    v.e_rv = e_rv; v.e_rb = e_rb; v.e_rs = e_rs;
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    i_nrst = 1'b0;
    idle();

    // reset state
    repeat (3) @(negedge i_clk);
    chk("rst_req_ready", o_req_ready, 0);
    chk("rst_req_valid", o_req_valid, 0);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_resp_rdata", o_resp_rdata, 0);
    chk("rst_resp_status", o_resp_status, 0);
    chk("rst_req_addr", o_req_addr, 0);
    chk("rst_req_wdata", o_req_wdata, 0);
    i_nrst = 1'b1;
    @(negedge i_clk);
    chk("rel_req_ready", o_req_ready, 1);
    chk("rel_req_valid", o_req_valid, 0);

    // single read, full FIFO, outstanding limit
    tbl[0]  = mkv(1, 48'h80001000, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0);
    tbl[1]  = mkv(0, 0, 1, 0, 8'h00, 0, 1, 1, 48'h80001000, 0, 8'h00, 0);
    tbl[2]  = mkv(0, 0, 0, 1, 8'hA5, 0, 1, 0, 0, 0, 8'h00, 0);
    tbl[3]  = mkv(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'hA5, 0);
    tbl[4]  = mkv(1, 48'h100, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'hA5, 0);
    tbl[5]  = mkv(1, 48'h140, 0, 0, 8'h00, 0, 1, 1, 48'h100, 0, 8'hA5, 0);
    tbl[6]  = mkv(1, 48'h180, 0, 0, 8'h00, 0, 0, 1, 48'h100, 0, 8'hA5, 0);
    tbl[7]  = mkv(1, 48'h180, 1, 0, 8'h00, 0, 0, 1, 48'h100, 0, 8'hA5, 0);
    tbl[8]  = mkv(0, 0, 1, 1, 8'h3C, 2, 1, 0, 0, 0, 8'hA5, 0);
    tbl[9]  = mkv(1, 48'h1C0, 1, 0, 8'h00, 0, 1, 1, 48'h140, 1, 8'h3C, 2);
    tbl[10] = mkv(0, 0, 1, 1, 8'h11, 0, 1, 0, 0, 0, 8'h3C, 2);
    tbl[11] = mkv(0, 0, 1, 0, 8'h00, 0, 1, 1, 48'h1C0, 1, 8'h11, 0);
    tbl[12] = mkv(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h11, 0);

    for (int i = 0; i < 13; i++) begin
      string n;
      n = $sformatf("vec%0d", i);
      chk({n, "_ready"}, o_req_ready, tbl[i].e_rdy);
      chk({n, "_valid"}, o_req_valid, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk({n, "_addr"}, o_req_addr, tbl[i].e_addr);
        chk({n, "_type"}, o_req_type, CACHED);
      end
      chk({n, "_rvalid"}, o_resp_valid, tbl[i].e_rv);
      chk({n, "_rdata"}, o_resp_rdata, {32{tbl[i].e_rb}});
      chk({n, "_rstatus"}, o_resp_status, tbl[i].e_rs);
      drive(tbl[i].pv, mk_req(tbl[i].addr));
      i_req_ready   = tbl[i].lr;
      i_resp_valid  = tbl[i].rv;
      i_resp_rdata  = {32{tbl[i].rb}};
      i_resp_status = tbl[i].rs;
      @(negedge i_clk);
    end
    idle();

    // wrap: six back-to-back requests with immediate responses
    begin
      int pushed;
      int nresp;
      logic popped;
      logic [47:0] issued[$];
      pushed = 0;
      nresp = 0;
      popped = 1'b0;
      reset_dut();
      for (int c = 0; c < 60 && nresp < 6; c++) begin
        if (o_resp_valid) nresp++;
        i_resp_valid = popped;
        i_resp_rdata = 256'(c);
        popped = 1'b0;
        if (o_req_valid) begin
          issued.push_back(o_req_addr);
          popped = 1'b1;
        end
        i_req_ready = 1'b1;
        drive((pushed < 6) && o_req_ready, mk_req(48'(pushed * 'h40)));
        if (i_req_valid) pushed++;
        @(negedge i_clk);
      end
      idle();
      chk("wrap_resp_count", nresp, 6);
      chk("wrap_issue_count", issued.size(), 6);
      for (int i = 0; i < issued.size() && i < 6; i++)
        chk($sformatf("wrap_order%0d", i), issued[i], 48'(i * 'h40));
    end

    // reset with two queued and one in flight
    reset_dut();
    drive(1'b1, mk_req(48'hA00));
    @(negedge i_clk);
    drive(1'b1, mk_req(48'hB00));
    i_req_ready = 1'b1;
    @(negedge i_clk);
    drive(1'b1, mk_req(48'hC00));
    @(negedge i_clk);
    idle();
    chk("mid_full_ready", o_req_ready, 0);
    chk("mid_blocked_valid", o_req_valid, 0);
    i_nrst = 1'b0;
    #1;
    chk("mid_rst_valid", o_req_valid, 0);
    chk("mid_rst_ready", o_req_ready, 0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    @(negedge i_clk);
    chk("mid_rel_ready", o_req_ready, 1);
    chk("mid_rel_valid", o_req_valid, 0);
    i_resp_valid = 1'b1;
    i_resp_rdata = {32{8'h77}};
    @(negedge i_clk);
    i_resp_valid = 1'b0;
    chk("late_resp_valid", o_resp_valid, 1);
    chk("late_resp_rdata", o_resp_rdata, {32{8'h77}});
    drive(1'b1, mk_req(48'hD00));
    @(negedge i_clk);
    idle();
    chk("late_outstd0_valid", o_req_valid, 1);
    chk("late_outstd0_addr", o_req_addr, 48'hD00);

    // randomized run against a queue model
    begin
      req_t mq[$];
      int m_out;
      logic m_rv;
      logic [255:0] m_rd;
      logic [1:0] m_rs;
      reset_dut();
      m_out = 0;
      m_rv = 1'b0;
      m_rd = '0;
      m_rs = '0;
      for (int c = 0; c < 3000; c++) begin
        logic m_rdy, m_vld, psh, pp;
        req_t r;
        m_rdy = mq.size() < DEPTH;
        m_vld = (mq.size() != 0) && (m_out < OMAX);
        chk("rnd_ready", o_req_ready, m_rdy);
        chk("rnd_valid", o_req_valid, m_vld);
        if (m_vld) begin
          chk("rnd_type", o_req_type, mq[0].t);
          chk("rnd_addr", o_req_addr, mq[0].a);
          chk("rnd_size", o_req_size, mq[0].s);
          chk("rnd_prot", o_req_prot, mq[0].p);
          chk("rnd_wdata", o_req_wdata, mq[0].d);
          chk("rnd_wstrb", o_req_wstrb, mq[0].b);
        end
        chk("rnd_rvalid", o_resp_valid, m_rv);
        chk("rnd_rdata", o_resp_rdata, m_rd);
        chk("rnd_rstatus", o_resp_status, m_rs);
        r = rand_req();
        drive($urandom_range(99) < 60, r);
        i_req_ready = $urandom_range(1);
        i_resp_valid = (m_out > 0) ? ($urandom_range(99) < 40)
                                   : ($urandom_range(99) < 5);
        for (int k = 0; k < 8; k++) i_resp_rdata[k*32 +: 32] = $urandom;
        i_resp_status = 2'($urandom);
        psh = i_req_valid && m_rdy;
        pp = m_vld && i_req_ready;
        if (pp) void'(mq.pop_front());
        if (psh) mq.push_back(r);
        if (pp && !i_resp_valid) m_out++;
        else if (!pp && i_resp_valid && m_out > 0) m_out--;
        m_rv = i_resp_valid;
        if (i_resp_valid) begin
          m_rd = i_resp_rdata;
          m_rs = i_resp_status;
        end
        @(negedge i_clk);
      end
      idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
